hack_cpu_core: RTL and testbench

- Multi-cycle Hack CPU datapath and control that sits directly upstream of the 16-bit ALU.
- Fetches instructions from synchronous-read instruction ROM and decodes A/C instructions.
- Drives the ALU control bits (zx, nx, zy, ny, f, no) and operands; the ALU is instantiated internally.
- Consumes ALU out/zr/ng to update the A, D and PC registers and data RAM; 3 cycles per instruction.

---
 rtl/hack_cpu_core.sv | 93 +++++++++
 tb/tb_hack_cpu_core.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hack_cpu_core.sv
// Multi-cycle Hack CPU core: FETCH / DECODE / EXEC, three cycles per instruction.
// The ALU is built in; ROM and RAM are external synchronous-read memories.
module hack_cpu_core #(
    parameter int              ADDR_W   = 15,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] pc_dbg,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       a_reg;
    logic [15:0]       d_reg;
    logic [15:0]       ir;

    logic        is_c;
    logic [15:0] alu_x, alu_y, x_z, x_n, y_z, y_n, alu_f, alu_out;
    logic        alu_zr, alu_ng, jump;
    logic        unused_ir_bits;

    assign is_c = ir[15];
    assign unused_ir_bits = ^ir[14:13];

    always_comb begin
        alu_x   = d_reg;
        alu_y   = ir[12] ? mem_rdata : a_reg;
        x_z     = ir[11] ? 16'h0000 : alu_x;
        x_n     = ir[10] ? ~x_z : x_z;
        y_z     = ir[9] ? 16'h0000 : alu_y;
        y_n     = ir[8] ? ~y_z : y_z;
        alu_f   = ir[7] ? (x_n + y_n) : (x_n & y_n);
        alu_out = ir[6] ? ~alu_f : alu_f;
        alu_zr  = (alu_out == 16'h0000);
        alu_ng  = alu_out[15];
        jump    = is_c & ((ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_ng & ~alu_zr));
    end

    // Write strobe must be combinational: the ALU result depends on mem_rdata,
    // which only becomes valid in EXEC itself.
    assign mem_we    = (state == EXEC) && is_c && ir[3];
    assign mem_wdata = alu_out;
    assign mem_addr  = a_reg[ADDR_W-1:0];
    assign rom_addr  = pc;
    assign pc_dbg    = pc;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            pc    <= RESET_PC;
            a_reg <= 16'h0000;
            d_reg <= 16'h0000;
            ir    <= 16'h0000;
        end else begin
            unique case (state)
                FETCH: state <= DECODE;
                DECODE: begin
                    ir    <= rom_data;
                    state <= EXEC;
                end
                EXEC: begin
                    state <= FETCH;
                    if (!is_c) begin
                        a_reg <= ir;
                        pc    <= pc + 1'b1;
                    end else begin
                        if (ir[5]) a_reg <= alu_out;
                        if (ir[4]) d_reg <= alu_out;
                        // Jump target is the A value from before this instruction's update.
                        pc <= jump ? a_reg[ADDR_W-1:0] : pc + 1'b1;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_cpu_core.sv
// Directed test of hack_cpu_core; RAM writes are checked by a scoreboard monitor,
// architectural state (PC, state, A via mem_addr) by end-of-program checks.
module tb_hack_cpu_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] rom_addr, mem_addr, pc_dbg;
    logic [15:0] rom_data, mem_rdata, mem_wdata;
    logic        mem_we;
    logic [1:0]  state_dbg;

    logic [15:0] rom [0:32767];
    logic [15:0] ram [0:32767];
    logic        pre_we = 1'b0;
    logic [14:0] pre_addr = '0;
    logic [15:0] pre_data = '0;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [14:0] a;
        logic [15:0] d;
    } wr_t;
    wr_t exp_q[$];

    hack_cpu_core #(.ADDR_W(15), .RESET_PC(15'd0)) dut (
        .clk       (clk),
        .reset     (reset),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .pc_dbg    (pc_dbg),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data  <= rom[rom_addr];
        mem_rdata <= ram[mem_addr];
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_we && !reset) ram[mem_addr] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin
        wr_t e;
        if (!reset && mem_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {17'd0, mem_addr}, {17'd0, e.a});
                check("wr_data", {16'd0, mem_wdata}, {16'd0, e.d});
            end
        end
    end

    task automatic ram_set(input logic [14:0] a, input logic [15:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic expect_wr(input logic [14:0] a, input logic [15:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Release reset at a falling edge and run a fixed number of cycles.
    task automatic run(input int cycles);
        @(negedge clk);
        reset = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic finish_prog(input string name, input logic [14:0] pc_exp);
        check({name, "_pc"}, {17'd0, pc_dbg}, {17'd0, pc_exp});
        check({name, "_state"}, {30'd0, state_dbg}, 32'd0);
        check({name, "_writes_left"}, exp_q.size(), 32'd0);
        exp_q.delete();
        reset = 1'b1;
    endtask

    initial begin
        // Reset values
        @(posedge clk);
        #1;
        check("rst_pc", {17'd0, pc_dbg}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_wdata", {16'd0, mem_wdata}, 32'd0);
        check("rst_addr", {17'd0, mem_addr}, 32'd0);

        // Reset asserted during EXEC of M=1 must abandon the write
        rom[0] = 16'h0003;
        rom[1] = 16'hEFC8;
        ram_set(15'd3, 16'h1234);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_state_exec", {30'd0, state_dbg}, 32'd2);
        check("mid_we_high", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_we_low", {31'd0, mem_we}, 32'd0);
        check("mid_pc", {17'd0, pc_dbg}, 32'd0);
        check("mid_state", {30'd0, state_dbg}, 32'd0);
        check("mid_a", {17'd0, mem_addr}, 32'd0);
        repeat (2) @(posedge clk);
        check("mid_ram3", {16'd0, ram[3]}, 32'h1234);

        // @5, D=A, @3, D=D+A, @100, M=D
        rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0003;
        rom[3] = 16'hE090; rom[4] = 16'h0064; rom[5] = 16'hE308;
        expect_wr(15'd100, 16'd8);
        run(18);
        check("add_ram100", {16'd0, ram[100]}, 32'd8);
        finish_prog("add", 15'd6);

        // @7, 0;JMP  -> taken
        rom[0] = 16'h0007; rom[1] = 16'hEA87;
        run(6);
        check("jeq_a", {17'd0, mem_addr}, 32'd7);
        finish_prog("jmp_taken", 15'd7);

        // @1, D=A, @7, D;JEQ -> not taken
        rom[0] = 16'h0001; rom[1] = 16'hEC10; rom[2] = 16'h0007; rom[3] = 16'hE302;
        run(12);
        finish_prog("jeq_not", 15'd4);

        // @9, D=-1, D;JLT -> taken on negative
        rom[0] = 16'h0009; rom[1] = 16'hEE90; rom[2] = 16'hE304;
        run(9);
        finish_prog("jlt", 15'd9);

        // @0x0F0F, D=A, @10, D=D&M, @11, M=D
        rom[0] = 16'h0F0F; rom[1] = 16'hEC10; rom[2] = 16'h000A;
        rom[3] = 16'hF010; rom[4] = 16'h000B; rom[5] = 16'hE308;
        ram_set(15'd10, 16'h00FF);
        expect_wr(15'd11, 16'h000F);
        run(18);
        finish_prog("and", 15'd6);

        // @20, AM=M+1, M=A  (write uses old A, then A=42)
        rom[0] = 16'h0014; rom[1] = 16'hFDE8; rom[2] = 16'hEC08;
        ram_set(15'd20, 16'd41);
        expect_wr(15'd20, 16'd42);
        expect_wr(15'd42, 16'd42);
        run(9);
        check("am_ram20", {16'd0, ram[20]}, 32'd42);
        check("am_a", {17'd0, mem_addr}, 32'd42);
        finish_prog("am", 15'd3);

        // Jump to 0x7FFF, execute A-instruction there, PC wraps
        rom[0] = 16'h7FFF; rom[1] = 16'hEA87; rom[32767] = 16'h0005;
        run(9);
        check("wrap_a", {17'd0, mem_addr}, 32'd5);
        finish_prog("wrap", 15'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
